dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the control unit (CPU side) and the host
//  loader that preloads matrices and reads results back. Arbitrates per access, issues
//  registered memory commands, returns read data tagged to its owner. Fixed CPU priority;
//  starvation guard; host bus lock for bursts.
// PARAMETERS
//  ADDR_W      16  data memory address width
//  DATA_W      16  data word width (matches BUS_WIDTH)
//  STARVE_LIM  4   consecutive CPU grants with host pending before host is forced a grant (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high reset
//  cpu_done    in   1       CU finished; host gets priority while high
//  cpu_req     in   1       CPU access request; held with cmd until cpu_gnt
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       comb.; request accepted this cycle
//  cpu_rvalid  out  1       read data for CPU valid on rdata
//  host_req    in   1       host access request; held until host_gnt
//  host_we     in   1       1 = write
//  host_addr   in   ADDR_W  host address
//  host_wdata  in   DATA_W  host write data
//  host_lock   in   1       host requests exclusive ownership across accesses
//  host_gnt    out  1       comb.; request accepted this cycle
//  host_rvalid out  1       read data for host valid on rdata
//  rdata       out  DATA_W  = mem_rdata (shared return bus, qualified by *_rvalid)
//  mem_en      out  1       registered memory command strobe
//  mem_we      out  1       registered write enable
//  mem_addr    out  ADDR_W  registered address
//  mem_wdata   out  DATA_W  registered write data
//  mem_rdata   in   DATA_W  sync-read RAM data, valid cycle after mem_en read
// BEHAVIOUR
//  Reset: state=ARB, starve_cnt=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, both rvalid=0,
//   in-flight read dropped (no rvalid after reset). gnt outputs comb., 0 while reset high.
//  Timing: req && gnt in cycle N -> mem_* driven in N+1 -> for reads, owner rvalid=1 in N+2
//   (1-cycle pulse). Writes produce no rvalid. One grant per cycle; back-to-back grants allowed,
//   throughput 1 access/cycle. mem_en=0 in cycles following no grant.
//  States: ARB (normal), HOST_LOCK (host owns port).
//  ARB grant rule, both requesting: host if cpu_done=1 or starve_cnt==STARVE_LIM, else CPU.
//   Single requester always granted.
//  starve_cnt: +1 on CPU grant while host_req=1 (saturate at STARVE_LIM); cleared on any
//   host grant or when host_req=0.
//  ARB->HOST_LOCK: host granted with host_lock=1. In HOST_LOCK only host granted, cpu_gnt=0.
//  HOST_LOCK->ARB: cycle host_lock samples 0; that cycle already arbitrates by ARB rule.
//  host_lock without host_req never grabs the port.
//  Read owner tag: 2-stage shift (valid, owner) alongside mem command; owner-exclusive rvalid.
//  cpu_rvalid and host_rvalid never both 1. rdata not registered.
// STRUCTURE
//  dmem_arb_pkg: state enum {ARB, HOST_LOCK}; owner encoding OWN_CPU=0, OWN_HOST=1.
//  Single module; no sub-module needed (grant logic + 2 pipeline regs + counter).
// TESTING
//  1 CPU read addr 0x0010, mem returns 0x1234 -> cpu_gnt N, mem_en/addr=0x0010 N+1,
//    cpu_rvalid=1 rdata=0x1234 N+2, host_rvalid stays 0.
//  2 Both req continuously, STARVE_LIM=4, cpu_done=0 -> grant pattern C,C,C,C,H repeating.
//  3 cpu_done=1, both req -> host granted every cycle; CPU granted only when host_req drops.
//  4 host_lock=1 over 3 writes 0x0100..0x0102 with cpu_req held -> cpu_gnt=0 throughout;
//    cpu_gnt=1 in cycle host_lock drops (host_req=0).
//  5 reset asserted in N+1 of a CPU read -> no cpu_rvalid in N+2, mem_en=0, state=ARB.
//  6 Host write 0xBEEF@0x0004 then CPU read 0x0004 back-to-back -> mem_we=1 then mem_we=0
//    on consecutive cycles; cpu_rvalid with rdata=0xBEEF.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and owner encodings for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {ARB = 1'b0, HOST_LOCK = 1'b1} state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_HOST = 1'b1} owner_e;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and the host loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  state_e state, state_n;
  logic [CW-1:0] starve_cnt, starve_n;
  logic lock_on, host_pri, rd_v1, rd_v2;
  owner_e rd_o1, rd_o2;
  // the cycle host_lock drops already arbitrates normally, so lock only holds while it is high
  always_comb begin
    lock_on = state == HOST_LOCK && host_lock;
    host_pri = cpu_done || starve_cnt == CW'(STARVE_LIM);
    host_gnt = !reset && host_req && (lock_on || !cpu_req || host_pri);
    cpu_gnt = !reset && cpu_req && !lock_on && !(host_req && host_pri);
    state_n = ((host_gnt && host_lock) || lock_on) ? HOST_LOCK : ARB;
    starve_n = (host_gnt || !host_req) ? '0 :
               (cpu_gnt && starve_cnt != CW'(STARVE_LIM)) ? starve_cnt + CW'(1) : starve_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      starve_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      rd_o1 <= OWN_CPU;
      rd_o2 <= OWN_CPU;
    end else begin
      state <= state_n;
      starve_cnt <= starve_n;
      mem_en <= cpu_gnt || host_gnt;
      mem_we <= host_gnt ? host_we : cpu_gnt && cpu_we;
      mem_addr <= host_gnt ? host_addr : cpu_gnt ? cpu_addr : mem_addr;
      mem_wdata <= host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : mem_wdata;
      rd_v1 <= host_gnt ? !host_we : cpu_gnt && !cpu_we;
      rd_o1 <= host_gnt ? OWN_HOST : OWN_CPU;
      rd_v2 <= rd_v1;
      rd_o2 <= rd_o1;
    end
  end
  assign cpu_rvalid = rd_v2 && rd_o2 == OWN_CPU;
  assign host_rvalid = rd_v2 && rd_o2 == OWN_HOST;
  assign rdata = mem_rdata;
endmodule
